// File: rtl/fifo_rr_sched_if.sv
// Bus between the round-robin scheduler and its FIFOs/downstream link.
// master = scheduler side, slave = FIFO/downstream side.
interface fifo_rr_sched_if #(
   parameter int N_INPUTS   = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int SEL_W = $clog2(N_INPUTS);

   logic [N_INPUTS-1:0]            empty_i;
   logic [N_INPUTS*DATA_WIDTH-1:0] data_i;
   logic [N_INPUTS-1:0]            rd_en_o;
   logic [DATA_WIDTH-1:0]          data_o;
   logic                           valid_o;
   logic                           ready_i;
   logic [SEL_W-1:0]               sel_o;

   modport master (
      input  empty_i, data_i, ready_i,
      output rd_en_o, data_o, valid_o, sel_o
   );

   modport slave (
      output empty_i, data_i, ready_i,
      input  rd_en_o, data_o, valid_o, sel_o
   );
endinterface

// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler: N FIFOs share one valid/ready output channel.
// Optional macro FIFO_RR_BURST_EN keeps priority on a FIFO for up to BURST_LEN reads.
module fifo_rr_sched #(
   parameter int N_INPUTS   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   fifo_rr_sched_if.master   bus
);
   localparam int SEL_W = $clog2(N_INPUTS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_INPUTS - 1);

   if ((N_INPUTS < 2) || (BURST_LEN < 1)) begin : g_param_check
      $error("fifo_rr_sched: N_INPUTS must be >= 2 and BURST_LEN >= 1");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [SEL_W-1:0]        r_ptr;
   logic [SEL_W-1:0]        r_sel;
   logic [SEL_W-1:0]        w_winner;
   logic                    w_any;
   logic                    w_valid;
   logic                    w_issue;
   logic [N_INPUTS-1:0]     w_rd_en;
   logic [DATA_WIDTH-1:0]   w_data;

   function automatic logic [SEL_W-1:0] f_next_idx(input logic [SEL_W-1:0] k);
      if (k == LAST_IDX) begin
         return '0;
      end else begin
         return k + SEL_W'(1);
      end
   endfunction

   assign w_valid = (r_state == ST_FULL);
   assign w_any   = |(~bus.empty_i);
   assign w_issue = (!w_valid || bus.ready_i) && w_any;

   // Scan from the pointer downwards so the lowest offset from r_ptr wins.
   always_comb begin
      w_winner = r_ptr;
      for (int i = N_INPUTS - 1; i >= 0; i--) begin
         logic [SEL_W-1:0] v_idx;
         v_idx = SEL_W'((int'(r_ptr) + i) % N_INPUTS);
         if (!bus.empty_i[v_idx]) begin
            w_winner = v_idx;
         end else begin
            w_winner = w_winner;
         end
      end
   end

   // One-hot read enable, suppressed while reset is asserted.
   always_comb begin
      w_rd_en = '0;
      if (w_issue && !rst_i) begin
         w_rd_en[w_winner] = 1'b1;
      end else begin
         w_rd_en = '0;
      end
   end

   // Output slot state: STREAM/STALL are the FULL state split by ready_i.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FULL: begin
            if (w_issue) begin
               w_state_nxt = ST_FULL;
            end else if (bus.ready_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Slot state and source index of the word on the output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_sel <= w_winner;
         end else begin
            r_sel <= r_sel;
         end
      end
   end

`ifdef FIFO_RR_BURST_EN
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   logic [CNT_W-1:0] r_burst_cnt;
   logic [CNT_W-1:0] w_cnt_base;

   // A read from a FIFO other than the held one starts a fresh burst.
   always_comb begin
      w_cnt_base = '0;
      if (w_winner == r_ptr) begin
         w_cnt_base = r_burst_cnt;
      end else begin
         w_cnt_base = '0;
      end
   end

   // Priority pointer with burst hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr       <= '0;
         r_burst_cnt <= '0;
      end else if (w_issue) begin
         if (w_cnt_base < CNT_LAST) begin
            r_ptr       <= w_winner;
            r_burst_cnt <= w_cnt_base + CNT_W'(1);
         end else begin
            r_ptr       <= f_next_idx(w_winner);
            r_burst_cnt <= '0;
         end
      end else if (bus.empty_i[r_ptr] && (r_burst_cnt != '0)) begin
         r_ptr       <= f_next_idx(r_ptr);
         r_burst_cnt <= '0;
      end else begin
         r_ptr       <= r_ptr;
         r_burst_cnt <= r_burst_cnt;
      end
   end
`else
   // Priority pointer: move just past the FIFO that was read.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (w_issue) begin
         r_ptr <= f_next_idx(w_winner);
      end else begin
         r_ptr <= r_ptr;
      end
   end
`endif

   // FIFO data registers only change on a read of that FIFO, so a mux suffices.
   always_comb begin
      w_data = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
         if (w_valid && (r_sel == SEL_W'(k))) begin
            w_data = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            w_data = w_data;
         end
      end
   end

   assign bus.rd_en_o = w_rd_en;
   assign bus.valid_o = w_valid;
   assign bus.sel_o   = r_sel;
   assign bus.data_o  = w_data;
endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched with simple registered-output FIFO models.
module tb_fifo_rr_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] mem [4][16];
   int         wr_cnt [4];
   int         rd_cnt [4];
   logic [7:0] fdata [4];
   logic [3:0] w_empty;

   fifo_rr_sched_if #(.N_INPUTS(4), .DATA_WIDTH(8)) bus ();

   fifo_rr_sched #(.N_INPUTS(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always_comb begin
      w_empty = '1;
      for (int k = 0; k < 4; k++) w_empty[k] = (rd_cnt[k] == wr_cnt[k]);
   end

   assign bus.empty_i = w_empty;
   assign bus.data_i  = {fdata[3], fdata[2], fdata[1], fdata[0]};

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bus.rd_en_o[k]) begin
            fdata[k]  <= mem[k][rd_cnt[k] % 16];
            rd_cnt[k] <= rd_cnt[k] + 1;
         end
      end
   end

   task automatic load(input int k, input logic [7:0] v);
      mem[k][wr_cnt[k] % 16] = v;
      wr_cnt[k] = wr_cnt[k] + 1;
   endtask

   task automatic begin_reset();
      rst = 1'b1;
      bus.ready_i = 1'b1;
      for (int k = 0; k < 4; k++) wr_cnt[k] = rd_cnt[k];
      @(posedge clk);
   endtask

   task automatic end_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      begin_reset();
      @(negedge clk);
      n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
      n_vec++; if (bus.rd_en_o !== 4'b0000) begin n_err++; $display("FAIL rst_rd_en: got %b want 0000", bus.rd_en_o); end
      n_vec++; if (bus.sel_o !== 2'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", bus.sel_o); end
      n_vec++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus.data_o); end
      for (int k = 0; k < 4; k++) begin
         load(k, 8'h90);
         load(k, 8'h91);
      end
      end_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", bus.valid_o); end
      n_vec++; if (bus.sel_o !== 2'd1) begin n_err++; $display("FAIL pre_rst_sel: got %0d want 1", bus.sel_o); end
      n_vec++; if (bus.rd_en_o !== 4'b0100) begin n_err++; $display("FAIL pre_rst_rd_en: got %b want 0100", bus.rd_en_o); end
      rst = 1'b1;
      #1;
      n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.valid_o); end
      n_vec++; if (bus.rd_en_o !== 4'b0000) begin n_err++; $display("FAIL mid_rst_rd_en: got %b want 0000", bus.rd_en_o); end
      n_vec++; if (bus.sel_o !== 2'd0) begin n_err++; $display("FAIL mid_rst_sel: got %0d want 0", bus.sel_o); end
      n_vec++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %h want 00", bus.data_o); end
      end_reset();
      @(negedge clk);
      n_vec++; if (bus.rd_en_o !== 4'b0001) begin n_err++; $display("FAIL post_rst_grant: got %b want 0001", bus.rd_en_o); end
      @(negedge clk);
      n_vec++; if (bus.data_o !== 8'h91) begin n_err++; $display("FAIL post_rst_data: got %h want 91", bus.data_o); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rd [6];
      logic [1:0] exp_sel [6];
      logic [7:0] exp_dat [6];
      exp_rd  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      exp_sel = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_dat = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
      begin_reset();
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 6; j++) load(k, 8'((k << 4) + j));
      end_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++; if (bus.rd_en_o !== exp_rd[c]) begin n_err++; $display("FAIL rr_rd_en[%0d]: got %b want %b", c, bus.rd_en_o, exp_rd[c]); end
         if (c > 0) begin
            n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", c, bus.valid_o); end
            n_vec++; if (bus.sel_o !== exp_sel[c]) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d want %0d", c, bus.sel_o, exp_sel[c]); end
            n_vec++; if (bus.data_o !== exp_dat[c]) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus.data_o, exp_dat[c]); end
         end
      end
   endtask

   task automatic test_skip_empties();
      logic [3:0] exp_rd [6];
      logic [1:0] exp_sel [6];
      logic [7:0] exp_dat [6];
      exp_rd  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
      exp_sel = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
      exp_dat = '{8'h00, 8'h40, 8'h70, 8'h41, 8'h71, 8'h42};
      begin_reset();
      for (int j = 0; j < 4; j++) begin
         load(1, 8'(8'h40 + j));
         load(3, 8'(8'h70 + j));
      end
      end_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++; if (bus.rd_en_o !== exp_rd[c]) begin n_err++; $display("FAIL skip_rd_en[%0d]: got %b want %b", c, bus.rd_en_o, exp_rd[c]); end
         if (c > 0) begin
            n_vec++; if (bus.sel_o !== exp_sel[c]) begin n_err++; $display("FAIL skip_sel[%0d]: got %0d want %0d", c, bus.sel_o, exp_sel[c]); end
            n_vec++; if (bus.data_o !== exp_dat[c]) begin n_err++; $display("FAIL skip_data[%0d]: got %h want %h", c, bus.data_o, exp_dat[c]); end
         end
      end
   endtask

   task automatic test_backpressure();
      begin_reset();
      bus.ready_i = 1'b0;
      load(2, 8'hA5);
      load(2, 8'h3C);
      end_reset();
      @(negedge clk);
      n_vec++; if (bus.rd_en_o !== 4'b0100) begin n_err++; $display("FAIL bp_first_rd: got %b want 0100", bus.rd_en_o); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.valid_o); end
         n_vec++; if (bus.data_o !== 8'hA5) begin n_err++; $display("FAIL bp_data[%0d]: got %h want a5", c, bus.data_o); end
         n_vec++; if (bus.sel_o !== 2'd2) begin n_err++; $display("FAIL bp_sel[%0d]: got %0d want 2", c, bus.sel_o); end
         n_vec++; if (bus.rd_en_o !== 4'b0000) begin n_err++; $display("FAIL bp_rd_en[%0d]: got %b want 0000", c, bus.rd_en_o); end
      end
      bus.ready_i = 1'b1;
      #1;
      n_vec++; if (bus.rd_en_o !== 4'b0100) begin n_err++; $display("FAIL bp_release_rd: got %b want 0100", bus.rd_en_o); end
      @(negedge clk);
      n_vec++; if (bus.data_o !== 8'h3C) begin n_err++; $display("FAIL bp_next_data: got %h want 3c", bus.data_o); end
      n_vec++; if (bus.rd_en_o !== 4'b0000) begin n_err++; $display("FAIL bp_drained_rd: got %b want 0000", bus.rd_en_o); end
      @(negedge clk);
      n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid: got %b want 0", bus.valid_o); end
      n_vec++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL bp_idle_data: got %h want 00", bus.data_o); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_rd [5];
      logic       exp_vld [5];
      logic [7:0] exp_dat [5];
      exp_rd  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_dat = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h00};
      begin_reset();
      for (int j = 0; j < 3; j++) load(0, 8'(8'h50 + j));
      end_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++; if (bus.rd_en_o !== exp_rd[c]) begin n_err++; $display("FAIL b2b_rd_en[%0d]: got %b want %b", c, bus.rd_en_o, exp_rd[c]); end
         n_vec++; if (bus.valid_o !== exp_vld[c]) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, bus.valid_o, exp_vld[c]); end
         n_vec++; if (bus.data_o !== exp_dat[c]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", c, bus.data_o, exp_dat[c]); end
      end
   endtask

`ifdef FIFO_RR_BURST_EN
   task automatic test_burst();
      logic [3:0] exp_rd [7];
      exp_rd = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
      begin_reset();
      load(0, 8'hE0);
      load(0, 8'hE1);
      for (int k = 1; k < 4; k++)
         for (int j = 0; j < 6; j++) load(k, 8'((k << 4) + j));
      end_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_vec++; if (bus.rd_en_o !== exp_rd[c]) begin n_err++; $display("FAIL burst_rd_en[%0d]: got %b want %b", c, bus.rd_en_o, exp_rd[c]); end
      end
   endtask
`endif

   initial begin
      bus.ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_cnt[k] = 0;
         fdata[k]  = 8'h00;
      end
      test_reset();
`ifdef FIFO_RR_BURST_EN
      test_burst();
`else
      test_round_robin();
`endif
      test_skip_empties();
      test_backpressure();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
